// File: rtl/pio_master_pkg.sv
// Shared types and constants for the PIO bus initiator.
package pio_master_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    WAIT = 3'd3,
    RESP = 3'd4
  } pio_master_state_e;

  localparam int PIO_MAX_NBITS = 64;

  // Read data returned to the host when the addressed block never answered.
  localparam logic [PIO_MAX_NBITS-1:0] PIO_TIMEOUT_RDATA = '1;

endpackage

// File: rtl/pio_master_timer.sv
// Beat-length down-counter and no-response up-counter, each with a terminal-count flag.
module pio_master_timer #(
  parameter int BEAT_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_beat_load,
  input  logic i_tmo_run,
  output logic o_beat_tc,
  output logic o_tmo_tc
);

  localparam logic [3:0]  BEAT_LOAD = 4'(BEAT_CYCLES - 1);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

  logic [3:0]  r_beat_cnt;
  logic [15:0] r_tmo_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat_cnt <= '0;
    end else if (i_beat_load) begin
      r_beat_cnt <= BEAT_LOAD;
    end else if (r_beat_cnt != 4'd0) begin
      r_beat_cnt <= r_beat_cnt - 4'd1;
    end
  end

  // Held at zero outside WAIT so the first WAIT cycle always sees a count of 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt <= '0;
    end else if (i_tmo_run) begin
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  assign o_beat_tc = (r_beat_cnt == 4'd0);
  assign o_tmo_tc  = (r_tmo_cnt == TMO_LAST);

endmodule

// File: rtl/pio_master.sv
// PIO bus initiator: one host request at a time, serialized as address/data beats.
// Optional transaction counters are built when PIO_MASTER_STATS_EN is defined.
module pio_master
  import pio_master_pkg::*;
#(
  parameter int PIO_NBITS      = 32,
  parameter int BEAT_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 host_req,
  input  logic                 host_rw,
  input  logic [PIO_NBITS-1:0] host_addr,
  input  logic [PIO_NBITS-1:0] host_wdata,
  output logic                 host_ready,
  output logic                 host_resp_valid,
  output logic [PIO_NBITS-1:0] host_rdata,
  output logic                 host_timeout,
  output logic                 pio_start,
  output logic                 pio_rw,
  output logic [PIO_NBITS-1:0] pio_addr_wdata,
  input  logic                 pio_ack,
  input  logic                 pio_rvalid,
  input  logic [PIO_NBITS-1:0] pio_rdata
`ifdef PIO_MASTER_STATS_EN
  ,
  input  logic                 stat_clr,
  output logic [15:0]          stat_wr_cnt,
  output logic [15:0]          stat_rd_cnt,
  output logic [15:0]          stat_timeout_cnt
`endif
);

  pio_master_state_e r_state;
  pio_master_state_e w_state_nxt;

  logic                 r_rw;
  logic [PIO_NBITS-1:0] r_wdata;
  logic                 r_sticky;
  logic [PIO_NBITS-1:0] r_rdata_cap;

  logic                 r_pio_start;
  logic                 r_pio_rw;
  logic [PIO_NBITS-1:0] r_pio_addr_wdata;
  logic                 r_host_resp_valid;
  logic [PIO_NBITS-1:0] r_host_rdata;
  logic                 r_host_timeout;

  logic                 w_beat_load;
  logic                 w_beat_tc;
  logic                 w_tmo_tc;
  logic                 w_resp_hit;
  logic                 w_done;
  logic                 w_tmo;
  logic [PIO_NBITS-1:0] w_rdata_resp;

  pio_master_timer #(
    .BEAT_CYCLES   (BEAT_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_beat_load(w_beat_load),
    .i_tmo_run  (r_state == WAIT),
    .o_beat_tc  (w_beat_tc),
    .o_tmo_tc   (w_tmo_tc)
  );

  // Only the response type matching the transaction counts; ack on a read is ignored.
  assign w_resp_hit = r_rw ? pio_rvalid : pio_ack;

  always_comb begin
    w_state_nxt = r_state;
    w_beat_load = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      IDLE: begin
        if (host_req) begin
          w_state_nxt = ADDR;
          w_beat_load = 1'b1;
        end
      end
      ADDR: begin
        if (w_beat_tc) begin
          if (r_rw) begin
            w_state_nxt = WAIT;
          end else begin
            w_state_nxt = DATA;
            w_beat_load = 1'b1;
          end
        end
      end
      DATA: begin
        if (w_beat_tc) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        w_done = r_sticky | w_resp_hit;
        w_tmo  = w_tmo_tc & ~w_done;
        if (w_done || w_tmo) begin
          w_state_nxt = RESP;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_rdata_resp = '0;
    if (w_tmo) begin
      w_rdata_resp = PIO_TIMEOUT_RDATA[PIO_NBITS-1:0];
    end else if (r_rw) begin
      w_rdata_resp = r_sticky ? r_rdata_cap : pio_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Early responses seen during the beats are remembered and consumed in WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rw        <= 1'b0;
      r_wdata     <= '0;
      r_sticky    <= 1'b0;
      r_rdata_cap <= '0;
    end else if (r_state == IDLE) begin
      if (host_req) begin
        r_rw     <= host_rw;
        r_wdata  <= host_wdata;
        r_sticky <= 1'b0;
      end
    end else if ((r_state == ADDR || r_state == DATA) && w_resp_hit && !r_sticky) begin
      r_sticky    <= 1'b1;
      r_rdata_cap <= pio_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pio_start       <= 1'b0;
      r_pio_rw          <= 1'b0;
      r_pio_addr_wdata  <= '0;
      r_host_resp_valid <= 1'b0;
      r_host_rdata      <= '0;
      r_host_timeout    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (host_req) begin
            r_pio_start      <= 1'b1;
            r_pio_rw         <= host_rw;
            r_pio_addr_wdata <= host_addr;
          end
        end
        ADDR: begin
          if (w_beat_tc) begin
            r_pio_start <= 1'b0;
            if (!r_rw) begin
              r_pio_rw         <= 1'b0;
              r_pio_addr_wdata <= r_wdata;
            end
          end
        end
        WAIT: begin
          if (w_done || w_tmo) begin
            r_host_resp_valid <= 1'b1;
            r_host_timeout    <= w_tmo;
            r_host_rdata      <= w_rdata_resp;
            r_pio_rw          <= 1'b0;
          end
        end
        RESP: begin
          r_host_resp_valid <= 1'b0;
          r_host_timeout    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign host_ready      = (r_state == IDLE);
  assign host_resp_valid = r_host_resp_valid;
  assign host_rdata      = r_host_rdata;
  assign host_timeout    = r_host_timeout;
  assign pio_start       = r_pio_start;
  assign pio_rw          = r_pio_rw;
  assign pio_addr_wdata  = r_pio_addr_wdata;

`ifdef PIO_MASTER_STATS_EN
  logic [15:0] r_stat_wr;
  logic [15:0] r_stat_rd;
  logic [15:0] r_stat_tmo;

  // Clear wins over a same-cycle increment; counters saturate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_wr  <= '0;
      r_stat_rd  <= '0;
      r_stat_tmo <= '0;
    end else if (stat_clr) begin
      r_stat_wr  <= '0;
      r_stat_rd  <= '0;
      r_stat_tmo <= '0;
    end else if (r_state == RESP) begin
      if (r_host_timeout) begin
        if (r_stat_tmo != 16'hFFFF) r_stat_tmo <= r_stat_tmo + 16'd1;
      end else if (r_rw) begin
        if (r_stat_rd != 16'hFFFF) r_stat_rd <= r_stat_rd + 16'd1;
      end else begin
        if (r_stat_wr != 16'hFFFF) r_stat_wr <= r_stat_wr + 16'd1;
      end
    end
  end

  assign stat_wr_cnt      = r_stat_wr;
  assign stat_rd_cnt      = r_stat_rd;
  assign stat_timeout_cnt = r_stat_tmo;
`endif

endmodule
